demux16_deser: RTL

//  Receive-side counterpart of the 16:1 bit-select mux path. Steers a serial bit

---
 rtl/demux16_pkg.sv | 22 ++
 rtl/demux1to4.sv | 14 +
 rtl/demux16_deser.sv | 106 ++++++++++
 3 files changed

// File: rtl/demux16_pkg.sv
// Shared constants, types and helpers for the 16-slot serial deserializer.
// Slot count is fixed at 16, so a 4-bit select addresses every slot.
package demux16_pkg;

    localparam int N     = 16;
    localparam int SEL_W = 4;

    typedef logic [N-1:0]     word_t;
    typedef logic [SEL_W-1:0] sel_t;

    localparam word_t ALL_ONES   = 16'hFFFF;
    localparam logic  MODE_COUNT = 1'b0;
    localparam logic  MODE_ADDR  = 1'b1;

    function automatic logic [SEL_W:0] popcount(input word_t v);
        logic [SEL_W:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + {{SEL_W{1'b0}}, v[i]};
        return c;
    endfunction

endpackage

// File: rtl/demux1to4.sv
// One-hot 1:4 decoder with enable.
// Used as one node of the 4:16 write-enable tree.
module demux1to4 (
    input  logic       i_en,
    input  logic [1:0] i_sel,
    output logic [3:0] o_y
);

    always_comb begin
        o_y        = 4'b0000;
        o_y[i_sel] = i_en;
    end

endmodule

// File: rtl/demux16_deser.sv
// Serial-to-parallel deserializer: steers bits into 16 slots (counter or external select)
// and hands completed words out through a single valid/ready holding register.
module demux16_deser
    import demux16_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_bit_in,
    input  logic             i_bit_valid,
    output logic             o_bit_ready,
    input  logic             i_addr_mode,
    input  logic [SEL_W-1:0] i_sel_in,
    input  logic             i_flush,
    output logic [N-1:0]     o_word_out,
    output logic             o_word_valid,
    input  logic             i_word_ready,
    output logic [SEL_W-1:0] o_sel_cnt
);

    word_t r_asm;
    word_t r_mask;
    word_t r_word;
    sel_t  r_sel_cnt;
    logic  r_mode_q;
    logic  r_word_valid;

    logic  w_last;
    logic  w_accept;
    logic  w_mode;
    logic  w_complete;
    sel_t  w_slot;
    logic [3:0] w_root;
    word_t w_we;
    word_t w_mask_nxt;
    word_t w_asm_nxt;

    // Stall only when the next bit could complete a word with nowhere to put it.
    assign w_last      = (popcount(r_mask) == (SEL_W+1)'(N-1));
    assign o_bit_ready = i_rst_n & ~(w_last & r_word_valid & ~i_word_ready);
    assign w_accept    = i_bit_valid & o_bit_ready & ~i_flush;

    // The first bit of a word uses the live mode input; it is then latched for the word.
    assign w_mode = (r_mask == '0) ? i_addr_mode : r_mode_q;
    assign w_slot = (w_mode == MODE_ADDR) ? i_sel_in
                  : (LSB_FIRST ? r_sel_cnt : SEL_W'(N-1) - r_sel_cnt);

    demux1to4 u_root (
        .i_en  (w_accept),
        .i_sel (w_slot[3:2]),
        .o_y   (w_root)
    );

    for (genvar g = 0; g < 4; g++) begin : g_leaf
        demux1to4 u_leaf (
            .i_en  (w_root[g]),
            .i_sel (w_slot[1:0]),
            .o_y   (w_we[g*4 +: 4])
        );
    end

    assign w_mask_nxt = r_mask | w_we;
    assign w_asm_nxt  = (r_asm & ~w_we) | (w_we & {N{i_bit_in}});
    assign w_complete = w_accept & (w_mask_nxt == ALL_ONES);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_asm        <= '0;
            r_mask       <= '0;
            r_sel_cnt    <= '0;
            r_mode_q     <= MODE_COUNT;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            if (i_flush) begin
                r_asm     <= '0;
                r_mask    <= '0;
                r_sel_cnt <= '0;
            end else if (w_accept) begin
                if (r_mask == '0) r_mode_q <= i_addr_mode;
                if (w_complete) begin
                    r_word    <= w_asm_nxt;
                    r_asm     <= '0;
                    r_mask    <= '0;
                    r_sel_cnt <= '0;
                end else begin
                    r_asm  <= w_asm_nxt;
                    r_mask <= w_mask_nxt;
                    if (w_mode == MODE_COUNT) r_sel_cnt <= r_sel_cnt + 1'b1;
                end
            end

            // A completion in the same cycle as a pop refills the holding register.
            if (w_complete)
                r_word_valid <= 1'b1;
            else if (r_word_valid && i_word_ready)
                r_word_valid <= 1'b0;
        end
    end

    assign o_word_out   = r_word;
    assign o_word_valid = r_word_valid;
    assign o_sel_cnt    = r_sel_cnt;

endmodule
